// File: rtl/mux_rr_arbiter.sv
// Round-robin N:1 flit arbiter with a one-entry registered output stage; optional packet locking.
// Latency: an accepted flit appears on out_* one rising edge after acceptance.
// Backpressure: req_ready is held low while the output register is full and out_ready is low.
//
// Ports:
//   clk, rst        : clock and asynchronous active-low reset
//   req_valid/data/last, req_ready : per-requester flit channels (requester i at data[i*DATA_W +: DATA_W])
//   out_valid/data/last, out_ready : registered downstream flit channel
//   grant           : one-hot packet owner (registered, zero when idle)
//   busy            : high while a packet owner holds the channel
//
// Build option: define MUX_ARB_PKT_LOCK_EN to hold the grant for a whole packet
// (until the flit with req_last). Without it every accepted flit is arbitrated
// on its own, so LOCKED is never entered and busy/grant stay 0.
module mux_rr_arbiter #(
    parameter int N_REQ  = 4,
    parameter int DATA_W = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_REQ-1:0]        req_valid,
    input  logic [N_REQ*DATA_W-1:0] req_data,
    input  logic [N_REQ-1:0]        req_last,
    output logic [N_REQ-1:0]        req_ready,
    output logic                    out_valid,
    output logic [DATA_W-1:0]       out_data,
    output logic                    out_last,
    input  logic                    out_ready,
    output logic [N_REQ-1:0]        grant,
    output logic                    busy
);

    localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [PTR_W-1:0]    ptr_q, ptr_d;
    logic [N_REQ-1:0]    grant_q, grant_d;
    logic                out_valid_q, out_valid_d;
    logic                out_last_q, out_last_d;
    logic [DATA_W-1:0]   out_data_q, out_data_d;

    logic                win_found;
    logic [PTR_W-1:0]    win_idx;
    logic [PTR_W-1:0]    own_idx;
    logic [PTR_W-1:0]    sel_idx;
    logic                sel_vld;
    logic [DATA_W-1:0]   sel_data;
    logic                sel_last;
    logic                can_load;
    logic                accept;
    logic                acc_last;

    // Round-robin search starting at ptr_q and wrapping; the first valid wins.
    always_comb begin : p_win
        logic [PTR_W:0] pos;
        win_found = 1'b0;
        win_idx   = '0;
        pos       = '0;
        for (int i = 0; i < N_REQ; i++) begin
            pos = {1'b0, ptr_q} + (PTR_W+1)'(i);
            if (pos >= (PTR_W+1)'(N_REQ)) begin
                pos = pos - (PTR_W+1)'(N_REQ);
            end
            if (!win_found && req_valid[pos[PTR_W-1:0]]) begin
                win_found = 1'b1;
                win_idx   = pos[PTR_W-1:0];
            end
        end
    end

    // Owner index recovered from the one-hot grant register.
    always_comb begin
        own_idx = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant_q[i]) begin
                own_idx = PTR_W'(i);
            end
        end
    end

    assign sel_idx  = (state_q == ST_LOCKED) ? own_idx : win_idx;
    assign sel_vld  = (state_q == ST_LOCKED) ? req_valid[own_idx] : win_found;
    assign can_load = !out_valid_q || out_ready;
    assign accept   = sel_vld && can_load;

    // Datapath mux: req_data only feeds the output register, never a port directly.
    always_comb begin
        sel_data = '0;
        sel_last = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            if (PTR_W'(i) == sel_idx) begin
                sel_data = req_data[i*DATA_W +: DATA_W];
                sel_last = req_last[i];
            end
        end
    end

`ifdef MUX_ARB_PKT_LOCK_EN
    assign acc_last = sel_last;
`else
    // Per-flit round-robin: every accepted flit closes its own grant.
    assign acc_last = 1'b1;
`endif

    // In LOCKED the owner's ready is offered even while it is not valid, so a
    // stalled owner keeps the channel and nobody else can slip in.
    always_comb begin
        req_ready = '0;
        if (rst && can_load && ((state_q == ST_LOCKED) || win_found)) begin
            req_ready[sel_idx] = 1'b1;
        end
    end

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        grant_d     = grant_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;
        if (accept) begin
            out_valid_d = 1'b1;
            out_data_d  = sel_data;
            out_last_d  = sel_last;
            if (acc_last) begin
                state_d = ST_IDLE;
                grant_d = '0;
                ptr_d   = (sel_idx == PTR_W'(N_REQ - 1)) ? '0 : sel_idx + PTR_W'(1);
            end else begin
                state_d          = ST_LOCKED;
                grant_d          = '0;
                grant_d[sel_idx] = 1'b1;
            end
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            ptr_q       <= '0;
            grant_q     <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            grant_q     <= grant_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_last  = out_last_q;
    assign grant     = grant_q;
    assign busy      = (state_q == ST_LOCKED);

endmodule

// File: doc/mux_rr_arbiter.md
# mux_rr_arbiter

Round-robin arbiter and registered output stage that shares one downstream flit channel among `N_REQ` requesters. It sits in front of the registered 2:1 (generalised to N:1) mux datapath in the BFT switch. It selects a requester, steers that requester's flit through the mux into a one-entry output register, and holds the grant for a whole packet until the `last` flit. Fairness is round-robin, and the priority pointer advances past each completed grant.

## Interface
Parameters:
- `N_REQ`, default 4: number of requesters; legal range 2..16.
- `DATA_W`, default 32: flit payload width.

Ports:
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `req_valid`  in  N_REQ  per-requester flit valid.
- `req_data`  in  N_REQ*DATA_W  flits; requester i occupies bits [i*DATA_W +: DATA_W].
- `req_last`  in  N_REQ  flit is the final flit of its packet.
- `req_ready`  out  N_REQ  flit accepted this cycle when `req_valid[i] & req_ready[i]`.
- `out_valid`  out  1  output register holds a flit.
- `out_data`  out  DATA_W  registered flit.
- `out_last`  out  1  registered last flag.
- `out_ready`  in  1  downstream accepts the output flit.
- `grant`  out  N_REQ  one-hot current owner, registered; all-zero when idle.
- `busy`  out  1  high in the LOCKED state.

## Operation
- State machine with two states.
  - IDLE: no owner. Winner = first requester with `req_valid` set, searching from `ptr` upward with wrap (`ptr`, `ptr+1`, … `N_REQ-1`, 0, …).
  - LOCKED: owner fixed in `grant`. Only the owner is considered.
- `can_load = !out_valid | out_ready`.
- `req_ready[i] = can_load & (i == winner in IDLE | i == owner in LOCKED)`. At most one bit is ever set. All bits are 0 when no valid request exists in IDLE.
- On an accepted flit from requester k:
  - load `out_data`/`out_last` from requester k and set `out_valid`;
  - if `req_last[k]`: go to (or stay in) IDLE, set `ptr = (k+1) mod N_REQ`, clear `grant`;
  - otherwise: go to LOCKED with `grant = onehot(k)`. `ptr` is unchanged.
- If `out_ready & out_valid` and no flit is accepted, clear `out_valid`.
- In LOCKED, the owner deasserting `req_valid` is legal. The lock is held indefinitely and no other requester is served.
- `out_data`/`out_last` are held stable while `out_valid & !out_ready`.
- Reset values:
  - `out_valid`=0, `out_data`=0, `out_last`=0;
  - `grant`=0, `busy`=0, `ptr`=0;
  - state IDLE;
  - `req_ready`=0 while `rst` is asserted.
- Reset asserted mid-packet drops the lock and the buffered flit. No flit is emitted after reset release until a new request is accepted.

## Timing
- Latency: accepted flit appears on `out_*` on the next rising edge.
- Throughput: 1 flit/cycle sustained when `out_ready` is held high.
- `req_ready` depends combinationally on `out_ready`, `req_valid`, state and `ptr`. No combinational path exists from `req_data` to any output.
- Back-to-back packets: a `last` accept in cycle t lets the next winner be accepted in cycle t+1 with no bubble.
- Single-flit packets do not enter LOCKED. `grant` stays 0 for them.
- `busy` is 1 in every cycle following a non-last accept, up to and including the cycle of the last accept.

## Configuration
- `MUX_ARB_PKT_LOCK_EN` defined: packet locking as described above.
- Not defined:
  - `req_last` is ignored for arbitration and every accepted flit is treated as last, giving per-flit round-robin;
  - LOCKED is never entered, so `busy` and `grant` are constant 0;
  - `out_last` still carries `req_last` of the accepted flit.

## Test plan
- Reset: drive `rst`=0 with all `req_valid`=1 → `out_valid`=0, `req_ready`=0, `grant`=0. Release reset → first accept is from requester 0.
- Fairness: `N_REQ`=4, all requesters stream single-flit packets with `out_ready`=1 → accept order is 0,1,2,3,0,1,… with one flit per cycle.
- Packet lock: requester 2 sends a 3-flit packet (`last` on the third flit) while 0 and 3 are valid → three consecutive flits from 2, `busy`=1 with `grant`=0100, then requester 3 wins.
- Backpressure: hold `out_ready`=0 for 5 cycles with a full output register → `out_data` is stable, `req_ready`=0. Raise `out_ready` → the next flit loads in the same cycle.
- Owner stall: owner 1 drops `req_valid` mid-packet for 4 cycles while 0 is valid → requester 0 gets no accept, and 1 resumes afterwards.
- Reset mid-packet: assert `rst` while LOCKED on requester 3 → `busy`=0, `out_valid`=0, `ptr`=0 after release. Without `MUX_ARB_PKT_LOCK_EN`, repeat the lock scenario → accepts interleave 2,3,0,2,….
